// File: rtl/btn_conditioner.sv
// Two-channel push-button conditioner: 2-flop synchronizer, debounce FSM,
// press/release pulses and an optional long-press pulse (BTN_LONGPRESS_EN).
//
// Ports:
//   sysclk      - single clock, all logic on its rising edge
//   reset       - synchronous, active-high reset
//   btn_raw     - asynchronous raw buttons (bit0 = BTNU, bit1 = BTND)
//   btn_level   - debounced, registered level per channel
//   btn_press   - one-cycle pulse on each accepted 0->1 transition
//   btn_release - one-cycle pulse on each accepted 1->0 transition
//   btn_long    - one-cycle pulse after LONG_CYCLES of hold; constant 0
//                 unless BTN_LONGPRESS_EN is defined
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_level,
    output logic [1:0] btn_press,
    output logic [1:0] btn_release,
    output logic [1:0] btn_long
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LO,
        S_CHK_HI,
        S_HI,
        S_CHK_LO
    } state_t;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [1:0]    sync_q;
        logic          sync;
        state_t        state;
        logic [CW-1:0] cnt;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          accept_hi;

        // sync_q[1] is the only flop allowed to feed the FSM
        always_ff @(posedge sysclk) begin
            if (reset) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], btn_raw[ch]};
            end
        end

        assign sync = sync_q[1];

        // Edge at which a rising change is accepted (entry to S_HI)
        assign accept_hi = (state == S_CHK_HI) && sync && (cnt == CNT_LAST);

        // The counter only advances below CNT_LAST, so it can never wrap
        always_ff @(posedge sysclk) begin
            if (reset) begin
                state     <= S_LO;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                unique case (state)
                    S_LO: begin
                        if (sync) begin
                            state <= S_CHK_HI;
                            cnt   <= '0;
                        end
                    end
                    S_CHK_HI: begin
                        if (!sync) begin
                            state <= S_LO;
                        end else if (cnt == CNT_LAST) begin
                            state   <= S_HI;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_HI: begin
                        if (!sync) begin
                            state <= S_CHK_LO;
                            cnt   <= '0;
                        end
                    end
                    S_CHK_LO: begin
                        if (sync) begin
                            state <= S_HI;
                        end else if (cnt == CNT_LAST) begin
                            state     <= S_LO;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_LO;
                    end
                endcase
            end
        end

`ifdef BTN_LONGPRESS_EN
        localparam int HW = $clog2(LONG_CYCLES) + 1;
        localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
        localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

        logic [HW-1:0] hold;

        // Hold counter parks at LONG_CYCLES after firing, so the pulse
        // cannot repeat until a new press clears it.
        always_ff @(posedge sysclk) begin
            if (reset) begin
                hold   <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (accept_hi) begin
                    hold <= '0;
                end else if (level_q && hold != HOLD_SAT) begin
                    hold <= hold + 1'b1;
                    if (hold == HOLD_LAST) begin
                        long_q <= 1'b1;
                    end
                end
            end
        end
`else
        assign long_q = 1'b0;
`endif

        assign btn_level[ch]   = level_q;
        assign btn_press[ch]   = press_q;
        assign btn_release[ch] = release_q;
        assign btn_long[ch]    = long_q;
    end

endmodule
